// File: rtl/dpm_rotmerge_pkg.sv
// Shared shift-control encodings (PRI_*/SEC_*) used by SRK and the DPM rotator, plus rotator payload types.
package dpm_rotmerge_pkg;

    localparam int unsigned ROTMERGE_W = 32;

    typedef enum logic [1:0] {
        PRI_EXTZ_RR = 2'd0,
        PRI_EXTZ_MR = 2'd1,
        PRI_EXTZ_MM = 2'd2,
        PRI_SECOND  = 2'd3
    } pri_e;

    typedef enum logic [3:0] {
        SEC_LITZERO = 4'd0,
        SEC_LITONE  = 4'd1,
        SEC_ASL_R   = 4'd2,
        SEC_ASL_M   = 4'd3,
        SEC_ASR_M   = 4'd4,
        SEC_LOB_OFF = 4'd5
    } sec_e;

    // Stage-1 capture payload, controls already converted to active-high
    typedef struct packed {
        logic [1:0]            pri;
        logic [5:0]            sec;
        logic [4:0]            shf;
        logic [ROTMERGE_W-1:0] r;
        logic [ROTMERGE_W-1:0] m;
    } s1_t;

    function automatic logic [3:0] odd_par(input logic [ROTMERGE_W-1:0] v);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i] = ~^v[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/dpm_rotmerge_core.sv
// Combinational funnel rotate, EXTZ mask and SECOND-function datapath for dpm_rotmerge.
module dpm_rotmerge_core
    import dpm_rotmerge_pkg::*;
(
    input  logic [1:0]            pri,
    input  logic [5:0]            sec,
    input  logic [4:0]            shf,
    input  logic [ROTMERGE_W-1:0] r,
    input  logic [ROTMERGE_W-1:0] m,
    output logic [ROTMERGE_W-1:0] res_c,
    output logic [1:0]            lane_c,
    output logic                  op_err_c
);

    localparam int unsigned W  = ROTMERGE_W;
    localparam int unsigned FW = 2 * ROTMERGE_W;

    logic [FW-1:0] funnel;
    logic [W-1:0]  rot;
    logic [W-1:0]  mask;
    logic [4:0]    shl;

    always_comb begin
        funnel   = {r, r};
        rot      = '0;
        mask     = '0;
        shl      = '0;
        res_c    = '0;
        lane_c   = '0;
        op_err_c = 1'b0;

        case (pri)
            PRI_EXTZ_MR: funnel = {m, r};
            PRI_EXTZ_MM: funnel = {m, m};
            default:     funnel = {r, r};
        endcase
        rot  = W'(funnel >> shf);
        mask = {W{1'b1}} >> (5'(W - 1) - sec[4:0]);
        // (32 - shf) mod 32 as two's complement negate
        shl  = ~shf + 5'd1;

        if (pri == PRI_SECOND) begin
            lane_c = sec[5:4];
            case (sec[3:0])
                SEC_LITZERO: res_c = '0;
                SEC_LITONE:  res_c = {{(W-1){1'b0}}, 1'b1} << shl;
                SEC_ASL_R:   res_c = r << shl;
                SEC_ASL_M:   res_c = m << shl;
                SEC_ASR_M:   res_c = W'($signed(m) >>> shf);
                SEC_LOB_OFF: res_c = r & ~(W'(8'hFF) << shf);
                default: begin
                    res_c    = '0;
                    op_err_c = 1'b1;
                end
            endcase
        end else begin
            res_c = rot & mask;
        end
    end

endmodule

// File: rtl/dpm_rotmerge.sv
// Two-stage stallable rotate/merge pipeline feeding the W-bus mux.
// Optional byte parity output enabled by defining ROTMERGE_PARITY_EN.
module dpm_rotmerge
    import dpm_rotmerge_pkg::*;
#(
    parameter int unsigned DW = ROTMERGE_W
) (
    input  logic          qd_clk_l,
    input  logic          reset_h,
    input  logic          in_valid_h,
    input  logic          stall_h,
    input  logic [1:0]    pri_l,
    input  logic [5:0]    sec_l,
    input  logic [4:0]    shf_l,
    input  logic [DW-1:0] r_h,
    input  logic [DW-1:0] m_h,
    output logic [DW-1:0] res_h,
    output logic          res_valid_h,
    output logic [1:0]    lane_h,
    output logic          zero_h,
    output logic          neg_h,
    output logic          op_err_h
`ifdef ROTMERGE_PARITY_EN
    ,
    output logic [3:0]    res_par_h
`endif
);

    s1_t           s1_d, s1_q;
    logic          s1_valid_d, s1_valid_q;
    logic [DW-1:0] res_d, res_q;
    logic          res_valid_d, res_valid_q;
    logic [1:0]    lane_d, lane_q;
    logic          zero_d, zero_q;
    logic          neg_d, neg_q;
    logic          op_err_d, op_err_q;

    logic [DW-1:0] core_res;
    logic [1:0]    core_lane;
    logic          core_err;

    dpm_rotmerge_core u_core (
        .pri      (s1_q.pri),
        .sec      (s1_q.sec),
        .shf      (s1_q.shf),
        .r        (s1_q.r),
        .m        (s1_q.m),
        .res_c    (core_res),
        .lane_c   (core_lane),
        .op_err_c (core_err)
    );

`ifdef ROTMERGE_PARITY_EN
    logic [3:0] par_d, par_q;
`endif

    // Next-state: stall freezes everything; results only update on a valid stage-1 op
    always_comb begin
        s1_d        = s1_q;
        s1_valid_d  = s1_valid_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        lane_d      = lane_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        op_err_d    = op_err_q;
`ifdef ROTMERGE_PARITY_EN
        par_d       = par_q;
`endif
        if (!stall_h) begin
            s1_valid_d  = in_valid_h;
            if (in_valid_h) begin
                s1_d.pri = ~pri_l;
                s1_d.sec = ~sec_l;
                s1_d.shf = ~shf_l;
                s1_d.r   = r_h;
                s1_d.m   = m_h;
            end
            res_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d    = core_res;
                lane_d   = core_lane;
                op_err_d = core_err;
                zero_d   = (core_res == '0);
                neg_d    = core_res[DW-1];
`ifdef ROTMERGE_PARITY_EN
                par_d    = odd_par(core_res);
`endif
            end
        end
    end

    always_ff @(posedge qd_clk_l) begin
        if (reset_h) begin
            s1_q        <= '0;
            s1_valid_q  <= 1'b0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            lane_q      <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            op_err_q    <= 1'b0;
`ifdef ROTMERGE_PARITY_EN
            par_q       <= '0;
`endif
        end else begin
            s1_q        <= s1_d;
            s1_valid_q  <= s1_valid_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            lane_q      <= lane_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            op_err_q    <= op_err_d;
`ifdef ROTMERGE_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign res_h       = res_q;
    assign res_valid_h = res_valid_q;
    assign lane_h      = lane_q;
    assign zero_h      = zero_q;
    assign neg_h       = neg_q;
    assign op_err_h    = op_err_q;
`ifdef ROTMERGE_PARITY_EN
    assign res_par_h   = par_q;
`endif

endmodule

// File: tb/tb_dpm_rotmerge.sv
// Directed self-checking bench for dpm_rotmerge; parity checks active when ROTMERGE_PARITY_EN is defined.
module tb_dpm_rotmerge;
    import dpm_rotmerge_pkg::*;

    logic        qd_clk_l;
    logic        reset_h;
    logic        in_valid_h;
    logic        stall_h;
    logic [1:0]  pri_l;
    logic [5:0]  sec_l;
    logic [4:0]  shf_l;
    logic [31:0] r_h;
    logic [31:0] m_h;
    logic [31:0] res_h;
    logic        res_valid_h;
    logic [1:0]  lane_h;
    logic        zero_h;
    logic        neg_h;
    logic        op_err_h;
`ifdef ROTMERGE_PARITY_EN
    logic [3:0]  res_par_h;
`endif

    int n_chk = 0;
    int n_err = 0;

    dpm_rotmerge #(.DW(32)) dut (
        .qd_clk_l    (qd_clk_l),
        .reset_h     (reset_h),
        .in_valid_h  (in_valid_h),
        .stall_h     (stall_h),
        .pri_l       (pri_l),
        .sec_l       (sec_l),
        .shf_l       (shf_l),
        .r_h         (r_h),
        .m_h         (m_h),
        .res_h       (res_h),
        .res_valid_h (res_valid_h),
        .lane_h      (lane_h),
        .zero_h      (zero_h),
        .neg_h       (neg_h),
        .op_err_h    (op_err_h)
`ifdef ROTMERGE_PARITY_EN
        ,
        .res_par_h   (res_par_h)
`endif
    );

    initial qd_clk_l = 1'b0;
    always #5 qd_clk_l = ~qd_clk_l;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge qd_clk_l);
        #1;
    endtask

    task automatic apply(input logic [1:0] pri, input logic [5:0] sec, input logic [4:0] shf,
                         input logic [31:0] r, input logic [31:0] m);
        in_valid_h = 1'b1;
        pri_l      = ~pri;
        sec_l      = ~sec;
        shf_l      = ~shf;
        r_h        = r;
        m_h        = m;
    endtask

    task automatic idle;
        in_valid_h = 1'b0;
        pri_l      = '1;
        sec_l      = '1;
        shf_l      = '1;
        r_h        = 32'hDEADBEEF;
        m_h        = 32'hDEADBEEF;
    endtask

    // One isolated op: capture edge, then result edge
    task automatic run(input logic [1:0] pri, input logic [5:0] sec, input logic [4:0] shf,
                       input logic [31:0] r, input logic [31:0] m);
        apply(pri, sec, shf, r, m);
        tick;
        idle;
        tick;
    endtask

    initial begin
        reset_h = 1'b1;
        stall_h = 1'b0;
        idle;
        tick;
        tick;
        chk("rst_valid", 32'(res_valid_h), 32'd0);
        chk("rst_res",   res_h,            32'd0);
        chk("rst_zero",  32'(zero_h),      32'd0);
        chk("rst_neg",   32'(neg_h),       32'd0);
        chk("rst_err",   32'(op_err_h),    32'd0);
        chk("rst_lane",  32'(lane_h),      32'd0);
`ifdef ROTMERGE_PARITY_EN
        chk("rst_par",   32'(res_par_h),   32'd0);
`endif
        reset_h = 1'b0;

        run(PRI_EXTZ_RR, 6'h3F, 5'd4, 32'h12345678, 32'h0);
        chk("rr_res",   res_h,            32'h81234567);
        chk("rr_neg",   32'(neg_h),       32'd1);
        chk("rr_zero",  32'(zero_h),      32'd0);
        chk("rr_valid", 32'(res_valid_h), 32'd1);
`ifdef ROTMERGE_PARITY_EN
        chk("rr_par",   32'(res_par_h),   32'b1000);
`endif

        run(PRI_EXTZ_MR, 6'h0F, 5'd8, 32'h11223344, 32'hAABBCCDD);
        chk("mr_res",  res_h,       32'h00002233);
        chk("mr_zero", 32'(zero_h), 32'd0);
        chk("mr_neg",  32'(neg_h),  32'd0);

        // sec 0 keeps only bit 0 of the rotated value (D1122334 -> 0)
        run(PRI_EXTZ_MR, 6'h00, 5'd4, 32'h11223344, 32'hAABBCCDD);
        chk("mr0_res",  res_h,       32'h0);
        chk("mr0_zero", 32'(zero_h), 32'd1);

        run(PRI_EXTZ_MM, 6'h3F, 5'd4, 32'h0, 32'h000000F0);
        chk("mm_res", res_h, 32'h0000000F);
        run(PRI_EXTZ_MM, 6'h07, 5'd0, 32'h0, 32'h12345678);
        chk("mm_mask8", res_h, 32'h00000078);

        run(PRI_SECOND, 6'h24, 5'd3, 32'h0, 32'h80000000);
        chk("asr_res",  res_h,       32'hF0000000);
        chk("asr_lane", 32'(lane_h), 32'd2);
        chk("asr_neg",  32'(neg_h),  32'd1);

        run(PRI_SECOND, 6'h01, 5'd0, 32'h0, 32'h0);
        chk("lit1_res",  res_h,       32'h1);
        chk("lit1_lane", 32'(lane_h), 32'd0);

        run(PRI_SECOND, 6'h02, 5'd4, 32'h000000F1, 32'h0);
        chk("aslr_res", res_h, 32'h10000000);
        run(PRI_SECOND, 6'h03, 5'd0, 32'h0, 32'h12345678);
        chk("aslm_shf0", res_h, 32'h12345678);
        run(PRI_SECOND, 6'h05, 5'd8, 32'hFFFFFFFF, 32'h0);
        chk("lob_res", res_h, 32'hFFFF00FF);

        run(PRI_SECOND, 6'h3F, 5'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("bad_res",  res_h,         32'h0);
        chk("bad_err",  32'(op_err_h), 32'd1);
        chk("bad_lane", 32'(lane_h),   32'd3);
        run(PRI_SECOND, 6'h00, 5'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("lit0_res",  res_h,         32'h0);
        chk("lit0_err",  32'(op_err_h), 32'd0);
        chk("lit0_zero", 32'(zero_h),   32'd1);

        run(PRI_SECOND, 6'h01, 5'd8, 32'h0, 32'h0);
        chk("lit1_s8", res_h, 32'h01000000);
`ifdef ROTMERGE_PARITY_EN
        chk("par_0111", 32'(res_par_h), 32'b0111);
`endif

        // Stream P, A, B, C with a 2-cycle stall while B waits at the input
        apply(PRI_EXTZ_RR, 6'h3F, 5'd0, 32'h0000000A, 32'h0);   // P
        tick;
        apply(PRI_EXTZ_RR, 6'h3F, 5'd0, 32'h000000A1, 32'h0);   // A
        tick;
        chk("st_p_res",   res_h,            32'h0000000A);
        chk("st_p_valid", 32'(res_valid_h), 32'd1);
        apply(PRI_EXTZ_RR, 6'h3F, 5'd0, 32'h000000B2, 32'h0);   // B
        stall_h = 1'b1;
        tick;
        chk("st_hold1_res",   res_h,            32'h0000000A);
        chk("st_hold1_valid", 32'(res_valid_h), 32'd1);
        tick;
        chk("st_hold2_res",   res_h,            32'h0000000A);
        stall_h = 1'b0;
        tick;
        chk("st_a_res",   res_h,            32'h000000A1);
        chk("st_a_valid", 32'(res_valid_h), 32'd1);
        apply(PRI_EXTZ_RR, 6'h3F, 5'd0, 32'h000000C3, 32'h0);   // C
        tick;
        chk("st_b_res", res_h, 32'h000000B2);
        idle;
        tick;
        chk("st_c_res",   res_h,            32'h000000C3);
        chk("st_c_valid", 32'(res_valid_h), 32'd1);
        tick;
        chk("st_end_valid", 32'(res_valid_h), 32'd0);
        chk("st_end_hold",  res_h,            32'h000000C3);

        // Reset mid-stream, asserted together with stall
        apply(PRI_SECOND, 6'h3F, 5'd0, 32'h0, 32'h0);            // X: sets op_err
        tick;
        apply(PRI_EXTZ_RR, 6'h3F, 5'd0, 32'h80000001, 32'h0);   // Y: in flight
        tick;
        chk("mr_x_err", 32'(op_err_h), 32'd1);
        idle;
        reset_h = 1'b1;
        stall_h = 1'b1;
        tick;
        reset_h = 1'b0;
        stall_h = 1'b0;
        chk("mrst_valid", 32'(res_valid_h), 32'd0);
        chk("mrst_res",   res_h,            32'd0);
        chk("mrst_err",   32'(op_err_h),    32'd0);
        chk("mrst_zero",  32'(zero_h),      32'd0);
        chk("mrst_neg",   32'(neg_h),       32'd0);
        tick;
        chk("mrst_nostale_valid", 32'(res_valid_h), 32'd0);
        chk("mrst_nostale_res",   res_h,            32'd0);
        tick;
        chk("mrst_nostale2_valid", 32'(res_valid_h), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
